// File: rtl/fc_pkg.sv
// Shared Fibre Channel word-sync definitions: comma character, sync-state
// encoding and the invalid-transmission-word classifier.
package fc_pkg;

    localparam logic [7:0] K28_5 = 8'hBC;

    typedef enum logic [1:0] {
        LOS  = 2'd0,
        ACQ  = 2'd1,
        SYNC = 2'd2
    } sync_state_t;

    // A K flag is only legal on byte 0, and only when that byte is the comma.
    function automatic logic fc_is_inv(
        input logic [7:0] byte0,
        input logic [3:0] k,
        input logic [3:0] kerr,
        input logic [3:0] rderr
    );
        return (|kerr) || (|rderr) || (|k[3:1]) || (k[0] && (byte0 != K28_5));
    endfunction

endpackage

// File: rtl/fc_word_sync.sv
// Fibre Channel transmission-word synchroniser: acquires sync on consecutive
// K28.5 ordered sets and drops it on a net excess of invalid words.
module fc_word_sync
    import fc_pkg::*;
#(
    parameter int ACQ_CNT = 3,
    parameter int LOS_CNT = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        din_val,
    input  logic [31:0] din_dat,
    input  logic [3:0]  din_k,
    input  logic [3:0]  din_kerr,
    input  logic [3:0]  din_rderr,
    input  logic        cnt_clr,
    output logic        dout_val,
    output logic [31:0] dout_dat,
    output logic [3:0]  dout_k,
    output logic        dout_inv,
    output logic        sync,
    output logic        los,
    output logic [15:0] err_count
);

    localparam int ACQ_W = $clog2(ACQ_CNT + 1);
    localparam int ERR_W = $clog2(LOS_CNT + 1);
    localparam logic [ACQ_W-1:0] ACQ_MAX = ACQ_W'(ACQ_CNT);
    localparam logic [ERR_W-1:0] ERR_MAX = ERR_W'(LOS_CNT);

    sync_state_t      r_state;
    sync_state_t      w_state_next;
    logic [ACQ_W-1:0] r_acq;
    logic [ACQ_W-1:0] w_acq_next;
    logic [ACQ_W-1:0] w_acq_inc;
    logic [ERR_W-1:0] r_err;
    logic [ERR_W-1:0] w_err_next;
    logic [ERR_W-1:0] w_err_inc;
    logic             r_pair;
    logic             w_pair_next;
    logic             w_inv;
    logic             w_os;

    logic             r_dout_val;
    logic [31:0]      r_dout_dat;
    logic [3:0]       r_dout_k;
    logic             r_dout_inv;
    logic             r_sync;
    logic             r_los;
    logic [15:0]      r_err_count;

    assign w_inv     = din_val && fc_is_inv(din_dat[7:0], din_k, din_kerr, din_rderr);
    assign w_os      = din_val && !w_inv && (din_k == 4'b0001) && (din_dat[7:0] == K28_5);
    assign w_acq_inc = r_acq + 1'b1;
    assign w_err_inc = r_err + 1'b1;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= LOS;
            r_acq   <= '0;
            r_err   <= '0;
            r_pair  <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_acq   <= w_acq_next;
            r_err   <= w_err_next;
            r_pair  <= w_pair_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_acq_next   = r_acq;
        w_err_next   = r_err;
        w_pair_next  = r_pair;
        if (din_val) begin
            case (r_state)
                LOS: begin
                    if (w_os) begin
                        w_acq_next = ACQ_W'(1);
                        if (ACQ_CNT == 1) begin
                            w_state_next = SYNC;
                            w_err_next   = '0;
                            w_pair_next  = 1'b0;
                        end else begin
                            w_state_next = ACQ;
                        end
                    end
                end
                ACQ: begin
                    if (w_inv) begin
                        w_state_next = LOS;
                        w_acq_next   = '0;
                    end else if (w_os) begin
                        w_acq_next = w_acq_inc;
                        if (w_acq_inc == ACQ_MAX) begin
                            w_state_next = SYNC;
                            w_err_next   = '0;
                            w_pair_next  = 1'b0;
                        end
                    end
                end
                SYNC: begin
                    if (w_inv) begin
                        w_pair_next = 1'b0;
                        if (w_err_inc == ERR_MAX) begin
                            w_state_next = LOS;
                            w_acq_next   = '0;
                            w_err_next   = '0;
                        end else begin
                            w_err_next = w_err_inc;
                        end
                    end else if (r_pair) begin
                        // Two consecutive good words earn back one error credit.
                        w_pair_next = 1'b0;
                        if (r_err != '0) begin
                            w_err_next = r_err - 1'b1;
                        end
                    end else begin
                        w_pair_next = 1'b1;
                    end
                end
                default: begin
                    w_state_next = LOS;
                    w_acq_next   = '0;
                    w_err_next   = '0;
                    w_pair_next  = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_dout_val  <= 1'b0;
            r_dout_dat  <= '0;
            r_dout_k    <= '0;
            r_dout_inv  <= 1'b0;
            r_sync      <= 1'b0;
            r_los       <= 1'b1;
            r_err_count <= '0;
        end else begin
            r_dout_val <= din_val;
            r_dout_dat <= din_dat;
            r_dout_k   <= din_k;
            r_dout_inv <= w_inv;
            r_sync     <= (w_state_next == SYNC);
            r_los      <= (w_state_next != SYNC);
            if (cnt_clr) begin
                r_err_count <= '0;
            end else if ((r_state == SYNC) && w_inv && (r_err_count != 16'hFFFF)) begin
                r_err_count <= r_err_count + 16'd1;
            end
        end
    end

    assign dout_val  = r_dout_val;
    assign dout_dat  = r_dout_dat;
    assign dout_k    = r_dout_k;
    assign dout_inv  = r_dout_inv;
    assign sync      = r_sync;
    assign los       = r_los;
    assign err_count = r_err_count;

endmodule

// File: doc/fc_word_sync.md
FC_WORD_SYNC -- requirements
Module: fc_word_sync

Interface
REQ-001 Parameter ACQ_CNT, default 3: consecutive valid ordered sets needed to acquire word sync.
REQ-002 Parameter LOS_CNT, default 4: net invalid-word count in SYNC that causes loss of sync.
REQ-003 clk  input  1  sole clock; all logic on rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 din_val  input  1  input word qualifier; low = bubble.
REQ-006 din_dat  input  32  decoded word from the x4 8b/10b decoder, little-endian, byte 0 at [7:0].
REQ-007 din_k  input  4  per-byte K flag; bit n = byte n.
REQ-008 din_kerr  input  4  per-byte code-violation flag.
REQ-009 din_rderr  input  4  per-byte running-disparity error flag.
REQ-010 cnt_clr  input  1  clears err_count.
REQ-011 dout_val  output  1  registered copy of din_val.
REQ-012 dout_dat  output  32  registered copy of din_dat.
REQ-013 dout_k  output  4  registered copy of din_k.
REQ-014 dout_inv  output  1  registered: this word is an invalid transmission word.
REQ-015 sync  output  1  word sync acquired.
REQ-016 los  output  1  loss of sync; always the inverse of sync.
REQ-017 err_count  output  16  saturating count of invalid words seen while in SYNC.

Function
REQ-018 Word classification (combinational, only when din_val=1): INV = any din_kerr or din_rderr bit set, or any of din_k[3:1] set, or din_k[0]=1 with din_dat[7:0] != 8'hBC.
REQ-019 OS (valid ordered set) = not INV, din_k=4'b0001, din_dat[7:0]=8'hBC (K28.5); any other non-INV word is DATA.
REQ-020 FSM states: LOS, ACQ, SYNC; acq counter (ACQ_CNT range), err counter 0..LOS_CNT-1, good-pair flag.
REQ-021 LOS: OS -> ACQ with acq=1 (or SYNC directly if ACQ_CNT=1); INV or DATA -> stay LOS.
REQ-022 ACQ: OS -> acq+1, entering SYNC with err=0 when acq reaches ACQ_CNT; DATA -> no change; INV -> LOS, acq=0.
REQ-023 SYNC: INV -> err+1, pair flag cleared; err reaching LOS_CNT -> LOS, acq=0.
REQ-024 SYNC: non-INV word with pair flag set -> err-1 (floor 0), flag cleared; non-INV with flag clear -> flag set.
REQ-025 din_val=0: no state, counter or flag change; dout_val=0.
REQ-026 All outputs registered; latency 1 cycle: the word causing a transition produces the new sync/los value in the following cycle, aligned with that word on dout_*.
REQ-027 err_count increments by 1 per INV word accepted in SYNC (including the word that causes loss), saturating at 16'hFFFF.
REQ-028 cnt_clr and an increment in the same cycle: clear wins, err_count=0 next cycle.
REQ-029 dout_inv reflects INV classification in every state, 0 when din_val=0.

Reset
REQ-030 rst=1 at any clock edge, including mid-acquisition or mid-SYNC: state LOS, acq=0, err=0, pair flag=0, err_count=0, dout_val=0, dout_dat=0, dout_k=0, dout_inv=0, sync=0, los=1; reset overrides all inputs.

Structure
REQ-031 Shared package fc_pkg holds K28_5 (8'hBC) and the sync-state enum (LOS, ACQ, SYNC).
REQ-032 Single flat module; no sub-module; one FSM process plus an output register stage.

Verification
REQ-033 After reset, three OS words (dat 32'h4A4A_B5BC style with k=0001) back to back -> sync=1 one cycle after third word; los=0.
REQ-034 OS, OS, word with din_kerr=4'b0100, OS -> stays LOS/ACQ, sync=0; three further OS -> sync=1.
REQ-035 In SYNC, four INV words separated by single DATA words -> sync drops to 0 one cycle after fourth INV; err_count=4.
REQ-036 In SYNC, INV, 2 DATA, INV, 2 DATA, INV, INV -> sync stays 1 (err peaks at 2).
REQ-037 din_val toggled low between OS words during acquisition -> bubbles ignored, sync after third OS; dout_val mirrors din_val delayed 1.
REQ-038 rst asserted for one cycle while in SYNC with err_count=7 and cnt_clr asserted with an INV -> all outputs at reset values, err_count=0, los=1.
